frame_rx: RTL and testbench
===========================

FRAME_RX -- requirements
Module: frame_rx

Interface
REQ-001 Parameter TIMEOUT_BITS, default 1024, SHALL set the number of enabled bit periods without a valid packet before the link is declared down; legal range 1..65535.
REQ-002 i_clk  input  1  SHALL be the single clock for all logic; one clock, same domain as the upstream recovery stage.
REQ-003 i_res_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 i_RecoveryData  input  1  SHALL carry the recovered serial bit; it is meaningful only when i_DataEn=1.
REQ-005 i_DataEn  input  1  SHALL be the one-cycle bit strobe; when it is low, no bit-level state advances.
REQ-006 o_Data  output  16  SHALL hold the payload {PL1,PL0} of the last valid packet.
REQ-007 o_DataValid  output  1  SHALL be a one-cycle pulse marking an update of o_Data.
REQ-008 o_ErrStrb  output  1  SHALL be a one-cycle pulse on any parity, framing or checksum error.
REQ-009 o_ErrCnt  output  8  SHALL be a saturating count of o_ErrStrb pulses.
REQ-010 o_LinkUp  output  1  SHALL be high while valid packets arrive within the timeout.

Function
REQ-011 Byte framing SHALL be: start bit 0, 8 data bits LSB first, even parity bit, stop bit 1; only i_DataEn=1 cycles count as bits.
REQ-012 Byte FSM states SHALL be IDLE, DATA, PARITY, STOP:
- IDLE->DATA on an enabled bit of 0; an enabled bit of 1 keeps IDLE.
- DATA->PARITY after 8 enabled bits.
- PARITY->STOP after 1 enabled bit.
- STOP->IDLE after 1 enabled bit.
REQ-013 A byte SHALL be good when the XOR of the 8 data bits and the parity bit is 0 and the stop bit is 1.
REQ-014 The byte FSM SHALL issue a good-byte or bad-byte event in cycle N+1, where N is the cycle of the stop-bit enable.
REQ-015 A stop bit of 0 SHALL be a framing error; that bit SHALL NOT be taken as a new start bit.
REQ-016 Packet FSM states SHALL be HDR, PL0, PL1, CHK, advancing one state per good byte.
REQ-017 In HDR, a good byte of 0xA5 SHALL advance to PL0; any other good byte SHALL be discarded silently, without an error, and the FSM stays in HDR.
REQ-018 In CHK, a good byte equal to PL0 XOR PL1 SHALL produce, in cycle N+2:
- o_Data <= {PL1,PL0};
- o_DataValid=1;
- packet FSM -> HDR.
REQ-019 In CHK, a good byte not matching the checksum SHALL produce o_ErrStrb=1 in cycle N+2 and return the FSM to HDR; o_Data is unchanged.
REQ-020 A bad byte in any packet state, including HDR, SHALL produce o_ErrStrb=1 in cycle N+2 and return the FSM to HDR.
REQ-021 o_DataValid and o_ErrStrb SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per event.
REQ-022 o_ErrCnt SHALL increment by 1 on each o_ErrStrb, hold at 255, and clear only by reset.
REQ-023 A 16-bit timeout counter SHALL behave as follows:
- clear to 0 on o_DataValid;
- otherwise increment on each i_DataEn=1 cycle while o_LinkUp=1;
- on the enabled bit that makes it equal TIMEOUT_BITS, clear o_LinkUp at that clock edge.
REQ-024 o_LinkUp SHALL be set in the same cycle as o_DataValid; if a valid packet and the timeout coincide, the valid packet wins and o_LinkUp stays 1.
REQ-025 o_Data SHALL hold its value between valid packets, including across errors and link-down.

Reset
REQ-026 On i_res_n=0, at any time including mid-byte or mid-packet, the block SHALL immediately:
- drive o_Data=0x0000, o_DataValid=0, o_ErrStrb=0, o_ErrCnt=0, o_LinkUp=0;
- set the byte FSM to IDLE, the packet FSM to HDR and all counters to 0.
REQ-027 After reset release, the first enabled 0 bit SHALL be treated as a start bit.

Verification
REQ-028 The bench SHALL cover the following directed scenarios; unless a scenario says otherwise, bytes are sent with i_DataEn every 3 cycles and idle bits are 1.
- Reset asserted mid-packet -> all outputs 0 within the same cycle; a subsequent full packet decodes correctly.
- Bytes A5,34,12,26 -> o_Data=0x1234; o_DataValid high for 1 cycle at N+2 after the last stop bit; o_LinkUp=1; o_ErrCnt=0.
- Bytes 55,A5,CD,AB,66 -> o_Data=0xABCD, valid; the 0x55 is ignored with no o_ErrStrb.
- Bytes A5, 34 with flipped parity, then A5,78,56,2E -> o_ErrStrb once, o_ErrCnt=1, then o_Data=0x5678 valid.
- Bytes A5,34,12,27 -> o_ErrStrb, no o_DataValid, o_Data keeps its previous value; stop bit forced to 0 on any byte -> o_ErrStrb.
- TIMEOUT_BITS=16, one valid packet, then idle 1s -> o_LinkUp falls at the 16th enabled bit edge; 300 errors -> o_ErrCnt=255.

Source files
------------

// File: rtl/frame_rx.sv
// Serial frame receiver: UART-style byte framing feeding a
// header/payload/checksum packet decoder with link-up timeout.
module frame_rx #(
    parameter int unsigned TIMEOUT_BITS = 1024
) (
    input  logic        i_clk,
    input  logic        i_res_n,
    input  logic        i_RecoveryData,
    input  logic        i_DataEn,
    output logic [15:0] o_Data,
    output logic        o_DataValid,
    output logic        o_ErrStrb,
    output logic [7:0]  o_ErrCnt,
    output logic        o_LinkUp
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [1:0] PK_HDR = 2'd0;
    localparam logic [1:0] PK_PL0 = 2'd1;
    localparam logic [1:0] PK_PL1 = 2'd2;
    localparam logic [1:0] PK_CHK = 2'd3;

    localparam logic [7:0]  HDR_BYTE = 8'hA5;
    localparam logic [15:0] TIMEOUT  = 16'(TIMEOUT_BITS);

    logic [1:0]  byteState;
    logic [2:0]  bitCnt;
    logic [7:0]  shiftReg;
    logic        parityBit;
    logic        byteGood;
    logic        byteBad;

    logic [1:0]  pktState;
    logic [7:0]  pl0;
    logic [7:0]  pl1;
    logic        chkMatch;
    logic        pktOk;
    logic        pktErr;

    logic [15:0] tmoCnt;
    logic [15:0] tmoNext;

    // Byte level: one step per enabled bit, event pulse the cycle after stop.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            byteState <= ST_IDLE;
            bitCnt    <= 3'd0;
            shiftReg  <= 8'h00;
            parityBit <= 1'b0;
            byteGood  <= 1'b0;
            byteBad   <= 1'b0;
        end else begin
            byteGood <= 1'b0;
            byteBad  <= 1'b0;
            if (i_DataEn) begin
                case (byteState)
                    ST_IDLE: begin
                        if (!i_RecoveryData) begin
                            byteState <= ST_DATA;
                            bitCnt    <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shiftReg <= {i_RecoveryData, shiftReg[7:1]};
                        bitCnt   <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            byteState <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parityBit <= i_RecoveryData;
                        byteState <= ST_STOP;
                    end
                    default: begin
                        if (i_RecoveryData && !(^{shiftReg, parityBit})) begin
                            byteGood <= 1'b1;
                        end else begin
                            byteBad <= 1'b1;
                        end
                        byteState <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign chkMatch = (shiftReg == (pl0 ^ pl1));
    assign pktOk    = byteGood && (pktState == PK_CHK) && chkMatch;
    assign pktErr   = byteBad || (byteGood && (pktState == PK_CHK) && !chkMatch);

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            pktState    <= PK_HDR;
            pl0         <= 8'h00;
            pl1         <= 8'h00;
            o_Data      <= 16'h0000;
            o_DataValid <= 1'b0;
            o_ErrStrb   <= 1'b0;
            o_ErrCnt    <= 8'h00;
        end else begin
            o_DataValid <= pktOk;
            o_ErrStrb   <= pktErr;
            if (pktOk) begin
                o_Data <= {pl1, pl0};
            end
            if (pktErr && (o_ErrCnt != 8'hFF)) begin
                o_ErrCnt <= o_ErrCnt + 8'd1;
            end
            if (byteBad) begin
                pktState <= PK_HDR;
            end else if (byteGood) begin
                case (pktState)
                    PK_HDR: begin
                        if (shiftReg == HDR_BYTE) begin
                            pktState <= PK_PL0;
                        end
                    end
                    PK_PL0: begin
                        pl0      <= shiftReg;
                        pktState <= PK_PL1;
                    end
                    PK_PL1: begin
                        pl1      <= shiftReg;
                        pktState <= PK_CHK;
                    end
                    default: pktState <= PK_HDR;
                endcase
            end
        end
    end

    assign tmoNext = tmoCnt + 16'd1;

    // A packet landing on the timeout edge keeps the link up.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            tmoCnt   <= 16'd0;
            o_LinkUp <= 1'b0;
        end else if (pktOk) begin
            tmoCnt   <= 16'd0;
            o_LinkUp <= 1'b1;
        end else if (i_DataEn && o_LinkUp) begin
            tmoCnt <= tmoNext;
            if (tmoNext == TIMEOUT) begin
                o_LinkUp <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_rx.sv
// Directed bench for frame_rx: packet decode, error paths,
// asynchronous reset, link timeout and error-count saturation.
module tb_frame_rx;

    logic        i_clk = 1'b0;
    logic        i_res_n = 1'b0;
    logic        i_RecoveryData = 1'b1;
    logic        i_DataEn = 1'b0;
    logic [15:0] o_Data;
    logic        o_DataValid;
    logic        o_ErrStrb;
    logic [7:0]  o_ErrCnt;
    logic        o_LinkUp;

    int vectors = 0;
    int miscompares = 0;
    int validSeen = 0;
    int errSeen = 0;
    int bothSeen = 0;
    int expErr = 0;

    frame_rx #(.TIMEOUT_BITS(16)) dut (
        .i_clk(i_clk),
        .i_res_n(i_res_n),
        .i_RecoveryData(i_RecoveryData),
        .i_DataEn(i_DataEn),
        .o_Data(o_Data),
        .o_DataValid(o_DataValid),
        .o_ErrStrb(o_ErrStrb),
        .o_ErrCnt(o_ErrCnt),
        .o_LinkUp(o_LinkUp)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_DataValid) validSeen++;
        if (o_ErrStrb) errSeen++;
        if (o_DataValid && o_ErrStrb) bothSeen++;
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sendBit(input logic b);
        i_RecoveryData = b;
        i_DataEn = 1'b1;
        step();
        i_DataEn = 1'b0;
        i_RecoveryData = 1'b1;
        step();
        step();
    endtask

    task automatic sendHead(input logic [7:0] b, input logic flipPar);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
        sendBit((^b) ^ flipPar);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic flipPar, input logic stopBit);
        sendHead(b, flipPar);
        sendBit(stopBit);
    endtask

    task automatic sendPacket(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] c);
        sendByte(8'hA5, 1'b0, 1'b1);
        sendByte(p0, 1'b0, 1'b1);
        sendByte(p1, 1'b0, 1'b1);
        sendByte(c, 1'b0, 1'b1);
        step();
        step();
    endtask

    task automatic checkIdleOutputs(input string tag);
        vectors++;
        if (o_Data !== 16'h0000) begin
            miscompares++;
            $display("FAIL %s o_Data got %h want 0000", tag, o_Data);
        end
        vectors++;
        if (o_DataValid !== 1'b0 || o_ErrStrb !== 1'b0) begin
            miscompares++;
            $display("FAIL %s strobes got v=%b e=%b want 0", tag, o_DataValid, o_ErrStrb);
        end
        vectors++;
        if (o_ErrCnt !== 8'h00) begin
            miscompares++;
            $display("FAIL %s o_ErrCnt got %0d want 0", tag, o_ErrCnt);
        end
        vectors++;
        if (o_LinkUp !== 1'b0) begin
            miscompares++;
            $display("FAIL %s o_LinkUp got %b want 0", tag, o_LinkUp);
        end
    endtask

    task automatic test_reset();
        i_res_n = 1'b0;
        step();
        checkIdleOutputs("reset");
        i_res_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_basic();
        int e0;
        e0 = errSeen;
        sendByte(8'hA5, 1'b0, 1'b1);
        sendByte(8'h34, 1'b0, 1'b1);
        sendByte(8'h12, 1'b0, 1'b1);
        sendHead(8'h26, 1'b0);
        i_RecoveryData = 1'b1;
        i_DataEn = 1'b1;
        step();
        i_DataEn = 1'b0;
        vectors++;
        if (o_DataValid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_n1 o_DataValid got %b want 0", o_DataValid);
        end
        step();
        vectors++;
        if (o_DataValid !== 1'b1 || o_Data !== 16'h1234) begin
            miscompares++;
            $display("FAIL basic_n2 v=%b data=%h want 1/1234", o_DataValid, o_Data);
        end
        vectors++;
        if (o_LinkUp !== 1'b1 || o_ErrCnt !== 8'h00) begin
            miscompares++;
            $display("FAIL basic_link link=%b errcnt=%0d want 1/0", o_LinkUp, o_ErrCnt);
        end
        step();
        vectors++;
        if (o_DataValid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_n3 o_DataValid got %b want 0", o_DataValid);
        end
        vectors++;
        if (errSeen != e0) begin
            miscompares++;
            $display("FAIL basic_err errstrb got %0d want 0", errSeen - e0);
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        sendByte(8'hA5, 1'b0, 1'b1);
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b0);
        vectors++;
        if (o_LinkUp !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre o_LinkUp got %b want 1", o_LinkUp);
        end
        i_res_n = 1'b0;
        #1;
        checkIdleOutputs("reset_mid");
        expErr = 0;
        step();
        i_res_n = 1'b1;
        step();
        v0 = validSeen;
        sendPacket(8'h78, 8'h56, 8'h2E);
        vectors++;
        if (validSeen != v0 + 1 || o_Data !== 16'h5678) begin
            miscompares++;
            $display("FAIL mid_post valid=%0d data=%h want 1/5678", validSeen - v0, o_Data);
        end
    endtask

    task automatic test_hdr_skip();
        int v0, e0;
        v0 = validSeen;
        e0 = errSeen;
        sendByte(8'h55, 1'b0, 1'b1);
        sendPacket(8'hCD, 8'hAB, 8'h66);
        vectors++;
        if (validSeen != v0 + 1 || o_Data !== 16'hABCD) begin
            miscompares++;
            $display("FAIL hdr_skip valid=%0d data=%h want 1/abcd", validSeen - v0, o_Data);
        end
        vectors++;
        if (errSeen != e0) begin
            miscompares++;
            $display("FAIL hdr_skip_err errstrb got %0d want 0", errSeen - e0);
        end
    endtask

    task automatic test_parity_err();
        int v0, e0;
        e0 = errSeen;
        sendByte(8'hA5, 1'b0, 1'b1);
        sendByte(8'h34, 1'b1, 1'b1);
        step();
        step();
        expErr++;
        vectors++;
        if (errSeen != e0 + 1 || o_ErrCnt !== 8'(expErr)) begin
            miscompares++;
            $display("FAIL parity errstrb=%0d errcnt=%0d want 1/%0d", errSeen - e0, o_ErrCnt, expErr);
        end
        vectors++;
        if (o_Data !== 16'hABCD) begin
            miscompares++;
            $display("FAIL parity_hold o_Data got %h want abcd", o_Data);
        end
        v0 = validSeen;
        sendPacket(8'h78, 8'h56, 8'h2E);
        vectors++;
        if (validSeen != v0 + 1 || o_Data !== 16'h5678) begin
            miscompares++;
            $display("FAIL parity_next valid=%0d data=%h want 1/5678", validSeen - v0, o_Data);
        end
    endtask

    task automatic test_chk_err();
        int v0, e0;
        v0 = validSeen;
        e0 = errSeen;
        sendPacket(8'h34, 8'h12, 8'h27);
        expErr++;
        vectors++;
        if (errSeen != e0 + 1 || validSeen != v0) begin
            miscompares++;
            $display("FAIL chk errstrb=%0d valid=%0d want 1/0", errSeen - e0, validSeen - v0);
        end
        vectors++;
        if (o_Data !== 16'h5678 || o_ErrCnt !== 8'(expErr)) begin
            miscompares++;
            $display("FAIL chk_hold data=%h errcnt=%0d want 5678/%0d", o_Data, o_ErrCnt, expErr);
        end
        e0 = errSeen;
        sendByte(8'hA5, 1'b0, 1'b0);
        step();
        step();
        expErr++;
        vectors++;
        if (errSeen != e0 + 1 || o_ErrCnt !== 8'(expErr)) begin
            miscompares++;
            $display("FAIL framing errstrb=%0d errcnt=%0d want 1/%0d", errSeen - e0, o_ErrCnt, expErr);
        end
    endtask

    task automatic test_timeout();
        sendPacket(8'h34, 8'h12, 8'h26);
        vectors++;
        if (o_LinkUp !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_up o_LinkUp got %b want 1", o_LinkUp);
        end
        for (int i = 0; i < 15; i++) sendBit(1'b1);
        vectors++;
        if (o_LinkUp !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_15 o_LinkUp got %b want 1", o_LinkUp);
        end
        sendBit(1'b1);
        vectors++;
        if (o_LinkUp !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_16 o_LinkUp got %b want 0", o_LinkUp);
        end
        vectors++;
        if (o_Data !== 16'h1234) begin
            miscompares++;
            $display("FAIL tmo_hold o_Data got %h want 1234", o_Data);
        end
    endtask

    task automatic test_err_sat();
        for (int i = 0; i < 300; i++) sendByte(8'h00, 1'b0, 1'b0);
        step();
        step();
        vectors++;
        if (o_ErrCnt !== 8'hFF) begin
            miscompares++;
            $display("FAIL err_sat o_ErrCnt got %0d want 255", o_ErrCnt);
        end
        vectors++;
        if (bothSeen != 0) begin
            miscompares++;
            $display("FAIL exclusive both strobes seen %0d want 0", bothSeen);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_reset_mid();
        test_hdr_skip();
        test_parity_err();
        test_chk_err();
        test_timeout();
        test_err_sat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
